// File: rtl/vga_pkg.sv
// Shared types, screen constants and FSM encodings for the plot sink.
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int FB_WORDS = 19200;

  typedef logic [7:0]  x_t;
  typedef logic [6:0]  y_t;
  typedef logic [2:0]  colour_t;
  typedef logic [14:0] fb_addr_t;

  typedef struct packed {
    x_t      x;
    y_t      y;
    colour_t colour;
  } pix_t;

  typedef enum logic {CL_IDLE, CL_RUN} clear_state_t;
  typedef enum logic [1:0] {SC_IDLE, SC_RUN, SC_DRAIN} scan_state_t;

  // Row stride of 160 built from two shifts so no multiplier is needed.
  function automatic fb_addr_t fb_addr(input x_t x, input y_t y);
    fb_addr_t yy;
    yy = {8'd0, y};
    return (yy << 7) + (yy << 5) + {7'd0, x};
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer: one write port, one registered read port.
// A read and write to the same address on one edge returns the old data.
module fb_ram
  import vga_pkg::*;
#(
  parameter int WORDS = FB_WORDS
) (
  input  logic     clk,
  input  logic     we,
  input  fb_addr_t waddr,
  input  colour_t  wdata,
  input  logic     re,
  input  fb_addr_t raddr,
  output colour_t  rdata
);

  colour_t mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_plot_sink.sv
// Plot-interface sink: writes plots into the framebuffer, runs a full-screen
// clear engine, and streams the picture back in raster order.
module vga_plot_sink
  import vga_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic    clk,
  input  logic    rst,
  input  x_t      vga_x,
  input  y_t      vga_y,
  input  colour_t vga_colour,
  input  logic    vga_plot,
  input  logic    clear_start,
  input  colour_t clear_colour,
  output logic    clear_busy,
  output logic    clear_done,
  input  logic    scan_start,
  output logic    scan_valid,
  input  logic    scan_ready,
  output x_t      scan_x,
  output y_t      scan_y,
  output colour_t scan_colour,
  output logic    scan_done,
  output logic    clipped,
  output logic    dropped
);

  localparam x_t       X_LIM   = x_t'(SCREEN_W);
  localparam y_t       Y_LIM   = y_t'(SCREEN_H);
  localparam x_t       X_LAST  = x_t'(SCREEN_W - 1);
  localparam y_t       Y_LAST  = y_t'(SCREEN_H - 1);
  localparam fb_addr_t CL_LAST = fb_addr_t'(SCREEN_W * SCREEN_H - 1);

  clear_state_t cl_state, cl_next;
  fb_addr_t     cl_cnt;
  colour_t      cl_colour;

  scan_state_t  sc_state, sc_next;
  x_t           sx, pend_x;
  y_t           sy, pend_y;
  logic         pend, issue, pop, scan_last, drain_empty;
  pix_t         skid [2];
  logic         wp, rp;
  logic [1:0]   count, occ;
  colour_t      rd_colour;
  pix_t         head;

  logic         plot_in_range, we;
  fb_addr_t     waddr;
  colour_t      wdata;

  // ---------------- clear engine ----------------
  always_comb begin
    cl_next = cl_state;
    unique case (cl_state)
      CL_IDLE: if (clear_start) cl_next = CL_RUN;
      CL_RUN:  if (cl_cnt == CL_LAST) cl_next = CL_IDLE;
      default: cl_next = CL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cl_state   <= CL_IDLE;
      cl_cnt     <= '0;
      cl_colour  <= '0;
      clear_done <= 1'b0;
    end else begin
      cl_state   <= cl_next;
      clear_done <= (cl_state == CL_RUN) && (cl_cnt == CL_LAST);
      if (cl_state == CL_IDLE && clear_start) begin
        cl_cnt    <= '0;
        cl_colour <= clear_colour;
      end else if (cl_state == CL_RUN) begin
        cl_cnt <= cl_cnt + 15'd1;
      end
    end
  end

  assign clear_busy = (cl_state == CL_RUN);

  // ---------------- write port ----------------
  // The clear owns the port; plots arriving meanwhile are discarded.
  assign plot_in_range = (vga_x < X_LIM) && (vga_y < Y_LIM);
  assign we            = clear_busy || (vga_plot && plot_in_range);
  assign waddr         = clear_busy ? cl_cnt : fb_addr(vga_x, vga_y);
  assign wdata         = clear_busy ? cl_colour : vga_colour;

  always_ff @(posedge clk) begin
    if (rst) begin
      clipped <= 1'b0;
      dropped <= 1'b0;
    end else begin
      if (vga_plot && !plot_in_range) clipped <= 1'b1;
      if (vga_plot && clear_busy)     dropped <= 1'b1;
    end
  end

  fb_ram u_fb_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (issue),
    .raddr (fb_addr(sx, sy)),
    .rdata (rd_colour)
  );

  // ---------------- scan engine ----------------
  // Handshake: a pixel moves on scan_valid && scan_ready; while valid is high
  // and ready low, the skid head (and so every scan_* output) is frozen.
  // A read is only issued if the buffer plus the read in flight still fits.
  assign pop         = scan_valid && scan_ready;
  assign occ         = count + {1'b0, pend};
  assign issue       = (sc_state == SC_RUN) && ((occ < 2'd2) || (occ == 2'd2 && pop));
  assign scan_last   = (sx == X_LAST) && (sy == Y_LAST);
  assign drain_empty = !pend && ((count == 2'd0) || (count == 2'd1 && pop));

  always_comb begin
    sc_next = sc_state;
    unique case (sc_state)
      SC_IDLE:  if (scan_start) sc_next = SC_RUN;
      SC_RUN:   if (issue && scan_last) sc_next = SC_DRAIN;
      SC_DRAIN: if (drain_empty) sc_next = SC_IDLE;
      default:  sc_next = SC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_state  <= SC_IDLE;
      sx        <= '0;
      sy        <= '0;
      pend      <= 1'b0;
      pend_x    <= '0;
      pend_y    <= '0;
      skid[0]   <= '0;
      skid[1]   <= '0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      count     <= '0;
      scan_done <= 1'b0;
    end else begin
      sc_state  <= sc_next;
      scan_done <= (sc_state == SC_DRAIN) && drain_empty;
      if (sc_state == SC_IDLE && scan_start) begin
        sx <= '0;
        sy <= '0;
      end else if (issue) begin
        if (sx == X_LAST) begin
          sx <= '0;
          sy <= sy + 7'd1;
        end else begin
          sx <= sx + 8'd1;
        end
      end
      pend <= issue;
      if (issue) begin
        pend_x <= sx;
        pend_y <= sy;
      end
      if (pend) begin
        skid[wp] <= {pend_x, pend_y, rd_colour};
        wp       <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, pend} - {1'b0, pop};
    end
  end

  assign head        = skid[rp];
  assign scan_valid  = (count != 2'd0);
  assign scan_x      = scan_valid ? head.x      : '0;
  assign scan_y      = scan_valid ? head.y      : '0;
  assign scan_colour = scan_valid ? head.colour : '0;

endmodule

// File: tb/tb_vga_plot_sink.sv
// Bench for vga_plot_sink: directed plots/clears, scans checked against an
// expected-pixel queue drained by an independent monitor.
module tb_vga_plot_sink;
  import vga_pkg::*;

  localparam int W = 18;

  logic    clk = 1'b0;
  logic    rst;
  x_t      vga_x;
  y_t      vga_y;
  colour_t vga_colour;
  logic    vga_plot;
  logic    clear_start;
  colour_t clear_colour;
  logic    clear_busy, clear_done;
  logic    scan_start, scan_valid, scan_ready, scan_done;
  x_t      scan_x;
  y_t      scan_y;
  colour_t scan_colour;
  logic    clipped, dropped;

  logic [W-1:0] exp_q[$];
  logic [2:0]   model_fb [FB_WORDS];
  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;

  vga_plot_sink dut (
    .clk          (clk),
    .rst          (rst),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_plot     (vga_plot),
    .clear_start  (clear_start),
    .clear_colour (clear_colour),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done),
    .scan_start   (scan_start),
    .scan_valid   (scan_valid),
    .scan_ready   (scan_ready),
    .scan_x       (scan_x),
    .scan_y       (scan_y),
    .scan_colour  (scan_colour),
    .scan_done    (scan_done),
    .clipped      (clipped),
    .dropped      (dropped)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic         prev_stall = 1'b0;
  logic [W:0]   prev_out = '0;
  always @(negedge clk) begin
    logic [W:0]   cur;
    logic [W-1:0] e;
    cur = {scan_valid, scan_x, scan_y, scan_colour};
    if (prev_stall) check("stall_hold", 32'(cur), 32'(prev_out));
    if (scan_done) done_cnt++;
    if (!rst && scan_valid && scan_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel got %0h exp none", cur[W-1:0]);
      end else begin
        e = exp_q.pop_front();
        check("pixel", 32'(cur[W-1:0]), 32'(e));
      end
      xfer_cnt++;
    end
    prev_stall = !rst && scan_valid && !scan_ready;
    prev_out   = cur;
  end

  // ---------------- driver tasks ----------------
  task automatic plot_px(input int x, input int y, input int c);
    vga_x      = x_t'(x);
    vga_y      = y_t'(y);
    vga_colour = colour_t'(c);
    vga_plot   = 1'b1;
    @(posedge clk); #1;
    vga_plot   = 1'b0;
    if (x < 160 && y < 120) model_fb[y * 160 + x] = colour_t'(c);
  endtask

  task automatic do_clear(input logic [2:0] c);
    int n;
    clear_colour = c;
    clear_start  = 1'b1;
    @(posedge clk); #1;
    clear_start  = 1'b0;
    clear_colour = 3'b111;
    check("clear_busy_start", 32'(clear_busy), 32'd1);
    n = 0;
    while (n < 30000) begin
      if (n == 100) begin
        vga_x = 8'd10; vga_y = 7'd10; vga_colour = 3'd5; vga_plot = 1'b1;
      end
      if (n == 101) vga_plot = 1'b0;
      if (n == 200) clear_start = 1'b1;
      if (n == 201) clear_start = 1'b0;
      @(posedge clk); #1;
      n++;
      if (clear_done) break;
    end
    check("clear_done_edge", 32'(n), 32'd19200);
    check("clear_busy_end", 32'(clear_busy), 32'd0);
    @(posedge clk); #1;
    check("clear_done_pulse", 32'(clear_done), 32'd0);
    for (int i = 0; i < FB_WORDS; i++) model_fb[i] = c;
  endtask

  task automatic do_scan(input bit rnd, input int abort_at, input bit timed);
    int n, first_valid, d0;
    exp_q.delete();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        exp_q.push_back({8'(x), 7'(y), model_fb[y * 160 + x]});
    d0 = done_cnt;
    xfer_cnt = 0;
    scan_ready = 1'b1;
    scan_start = 1'b1;
    @(posedge clk); #1;
    scan_start = 1'b0;
    n = 0;
    first_valid = -1;
    while (n < 60000) begin
      if (rnd) scan_ready = ($urandom_range(0, 3) != 0);
      if (n == 1000) scan_start = 1'b1;
      if (n == 1001) scan_start = 1'b0;
      @(posedge clk); #1;
      n++;
      if (scan_valid && first_valid < 0) first_valid = n;
      if (abort_at > 0 && xfer_cnt >= abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_xfers", 32'(xfer_cnt), 32'(abort_at));
        check("abort_valid", 32'(scan_valid), 32'd0);
        check("abort_busy", 32'(clear_busy), 32'd0);
        check("abort_clipped", 32'(clipped), 32'd0);
        check("abort_dropped", 32'(dropped), 32'd0);
        exp_q.delete();
        repeat (5) @(posedge clk);
        #1;
        check("abort_idle_valid", 32'(scan_valid), 32'd0);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        return;
      end
      if (scan_done) break;
    end
    check("scan_first_valid", 32'(first_valid), 32'd2);
    if (timed) check("scan_done_edge", 32'(n), 32'd19202);
    check("scan_done_seen", 32'(scan_done), 32'd1);
    check("scan_queue_empty", 32'(exp_q.size()), 32'd0);
    check("scan_xfers", 32'(xfer_cnt), 32'd19200);
    @(posedge clk); #1;
    check("scan_done_pulse", 32'(scan_done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("scan_done_once", 32'(done_cnt - d0), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
    clear_start = 1'b0; clear_colour = '0;
    scan_start = 1'b0; scan_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_clear_busy", 32'(clear_busy), 32'd0);
    check("rst_clear_done", 32'(clear_done), 32'd0);
    check("rst_scan_valid", 32'(scan_valid), 32'd0);
    check("rst_scan_x", 32'(scan_x), 32'd0);
    check("rst_scan_y", 32'(scan_y), 32'd0);
    check("rst_scan_colour", 32'(scan_colour), 32'd0);
    check("rst_scan_done", 32'(scan_done), 32'd0);
    check("rst_clipped", 32'(clipped), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_clear(3'b010);
    check("clipped_after_clear", 32'(clipped), 32'd0);
    check("dropped_after_clear", 32'(dropped), 32'd1);

    plot_px(0, 0, 1);
    plot_px(159, 119, 7);
    plot_px(80, 60, 4);
    plot_px(160, 5, 3);
    plot_px(5, 120, 3);
    check("clipped_set", 32'(clipped), 32'd1);

    do_scan(1'b1, 0, 1'b0);
    scan_ready = 1'b1;
    do_scan(1'b0, 500, 1'b0);
    do_scan(1'b0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
